// File: rtl/prefetcher_pkg.sv
// Opcodes and queue entry layout shared by the prefetch controller and the prefetch data queue.
package prefetcher_pkg;

  localparam int unsigned PF_ADDR_BITS = 64;
  localparam int unsigned PF_MAX_BEATS = 4;
  localparam int unsigned PF_BEAT_W    = $clog2(PF_MAX_BEATS + 1);

  typedef enum logic [2:0] {
    PR_NOP          = 3'd0,
    PR_REQ_PREF     = 3'd1,
    PR_REQ_MASTER   = 3'd2,
    PR_DATA_SLAVE   = 3'd3,
    PR_DATA_PROMISE = 3'd4
  } pr_opcode_e;

  // wr_beat counts up to MAX_BEATS so it needs one bit more than a beat index.
  typedef struct packed {
    logic                    valid;
    logic [PF_ADDR_BITS-1:0] addr;
    logic                    outstanding;
    logic                    promised;
    logic [PF_BEAT_W-1:0]    wr_beat;
    logic [PF_BEAT_W-1:0]    rd_beat;
    logic [PF_BEAT_W-1:0]    last_beat;
  } pf_entry_t;

endpackage

// File: rtl/prefetch_addr_cam.sv
// Parallel address compare over all queue entries; the oldest match counting from head wins.
module prefetch_addr_cam
  import prefetcher_pkg::*;
#(
  parameter int unsigned ADDR_BITS      = PF_ADDR_BITS,
  parameter int unsigned LOG_QUEUE_SIZE = 6
) (
  input  logic [(2**LOG_QUEUE_SIZE)-1:0]                match_en,
  input  logic [(2**LOG_QUEUE_SIZE)-1:0][ADDR_BITS-1:0] entry_addr,
  input  logic [ADDR_BITS-1:0]                          key,
  input  logic [LOG_QUEUE_SIZE-1:0]                     head,
  output logic                                          hit,
  output logic [LOG_QUEUE_SIZE-1:0]                     index
);

  localparam int unsigned ENTRIES = 2**LOG_QUEUE_SIZE;

  logic [ENTRIES-1:0]        match;
  logic [LOG_QUEUE_SIZE-1:0] scan_idx;

  always_comb begin
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      match[i] = match_en[i] && (entry_addr[i] == key);
    end
  end

  // Walk from head towards tail so the first match found is the oldest.
  always_comb begin
    hit      = 1'b0;
    index    = head;
    scan_idx = head;
    for (int unsigned k = 0; k < ENTRIES; k++) begin
      scan_idx = head + LOG_QUEUE_SIZE'(k);
      if (!hit && match[scan_idx]) begin
        hit   = 1'b1;
        index = scan_idx;
      end
    end
  end

endmodule

// File: rtl/prefetch_data_queue.sv
// Circular queue of prefetched blocks executing the prefetch controller's opcodes.
// Optional statistics counters: define PREFETCH_QUEUE_STATS_EN.
module prefetch_data_queue
  import prefetcher_pkg::*;
#(
  parameter int unsigned ADDR_BITS          = PF_ADDR_BITS,
  parameter int unsigned LOG_QUEUE_SIZE     = 6,
  parameter int unsigned DATA_WIDTH         = 64,
  parameter int unsigned MAX_BEATS          = PF_MAX_BEATS,
  parameter int unsigned ALMOST_FULL_MARGIN = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      pr_flush,
  input  logic [2:0]                pr_opCode,
  input  logic [ADDR_BITS-1:0]      pr_m_ar_addr,
  input  logic [DATA_WIDTH-1:0]     m_r_data,
  input  logic                      m_r_last,
  output logic                      pr_addrHit,
  output logic                      pr_hasOutstanding,
  output logic [LOG_QUEUE_SIZE:0]   pr_reqCnt,
  output logic                      pr_almostFull,
  output logic                      pr_r_valid,
  output logic                      pr_r_in_last,
  output logic [DATA_WIDTH-1:0]     pr_r_data,
`ifdef PREFETCH_QUEUE_STATS_EN
  output logic [31:0]               stat_hits,
  output logic [31:0]               stat_misses,
  output logic [31:0]               stat_skips,
`endif
  output logic                      pr_err
);

  localparam int unsigned ENTRIES = 2**LOG_QUEUE_SIZE;
  localparam int unsigned PTR_W   = LOG_QUEUE_SIZE;
  localparam int unsigned CNT_W   = LOG_QUEUE_SIZE + 1;
  localparam int unsigned BEAT_W  = PF_BEAT_W;
  localparam int unsigned BIDX_W  = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

  pf_entry_t             q        [ENTRIES];
  logic [DATA_WIDTH-1:0] beat_mem [ENTRIES][MAX_BEATS];
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [CNT_W-1:0]      cnt;

  logic op_pref, op_master, op_slave, op_promise, op_bad;
  logic full, any_promised, has_out;
  logic [ENTRIES-1:0]                cam_en;
  logic [ENTRIES-1:0][ADDR_BITS-1:0] cam_addr;
  logic                              cam_hit;
  logic [PTR_W-1:0]                  cam_idx;
  logic                              fill_found;
  logic [PTR_W-1:0]                  fill_idx;
  logic [PTR_W-1:0]                  scan_idx;
  logic alloc_req, alloc, alloc_err;
  logic fill_en, fill_drop, fill_err;
  logic drain, drain_pop, drain_err, skip, pop, err_set;

  // Opcode decode; a flush suppresses every opcode in its cycle.
  always_comb begin
    op_pref    = 1'b0;
    op_master  = 1'b0;
    op_slave   = 1'b0;
    op_promise = 1'b0;
    op_bad     = 1'b0;
    if (!pr_flush) begin
      case (pr_opCode)
        PR_NOP:          ;
        PR_REQ_PREF:     op_pref    = 1'b1;
        PR_REQ_MASTER:   op_master  = 1'b1;
        PR_DATA_SLAVE:   op_slave   = 1'b1;
        PR_DATA_PROMISE: op_promise = 1'b1;
        default:         op_bad     = 1'b1;
      endcase
    end
  end

  always_comb begin
    any_promised = 1'b0;
    has_out      = 1'b0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      cam_en[i]    = q[i].valid && !q[i].promised;
      cam_addr[i]  = ADDR_BITS'(q[i].addr);
      any_promised = any_promised | (q[i].valid & q[i].promised);
      has_out      = has_out | (q[i].valid & q[i].outstanding);
    end
  end

  prefetch_addr_cam #(
    .ADDR_BITS      (ADDR_BITS),
    .LOG_QUEUE_SIZE (LOG_QUEUE_SIZE)
  ) u_cam (
    .match_en   (cam_en),
    .entry_addr (cam_addr),
    .key        (pr_m_ar_addr),
    .head       (head),
    .hit        (cam_hit),
    .index      (cam_idx)
  );

  // DDR returns in order, so the fill target is always the oldest outstanding entry.
  always_comb begin
    fill_found = 1'b0;
    fill_idx   = head;
    scan_idx   = head;
    for (int unsigned k = 0; k < ENTRIES; k++) begin
      scan_idx = head + PTR_W'(k);
      if (!fill_found && q[scan_idx].valid && q[scan_idx].outstanding) begin
        fill_found = 1'b1;
        fill_idx   = scan_idx;
      end
    end
  end

  assign full          = (cnt == CNT_W'(ENTRIES));
  assign pr_reqCnt     = cnt;
  assign pr_almostFull = ((CNT_W'(ENTRIES) - cnt) <= CNT_W'(ALMOST_FULL_MARGIN));
  assign pr_hasOutstanding = has_out;
  assign pr_addrHit    = op_master & cam_hit;

  assign pr_r_valid   = q[head].valid && q[head].promised && (q[head].rd_beat < q[head].wr_beat);
  assign pr_r_in_last = q[head].valid && !q[head].outstanding && (q[head].rd_beat == q[head].last_beat);
  assign pr_r_data    = pr_r_valid ? beat_mem[head][BIDX_W'(q[head].rd_beat)] : '0;

  assign alloc_req = op_pref | (op_master & ~cam_hit);
  assign alloc     = alloc_req & ~full;
  assign alloc_err = alloc_req & full;

  assign fill_en   = op_slave & fill_found;
  assign fill_err  = op_slave & ~fill_found;
  assign fill_drop = fill_en && (q[fill_idx].wr_beat >= BEAT_W'(MAX_BEATS));

  assign drain     = op_promise & pr_r_valid;
  assign drain_pop = drain & pr_r_in_last;
  assign drain_err = op_promise & ~pr_r_valid;

  // A stale unpromised head is dropped once a younger promised block exists, unless it is being hit now.
  assign skip = !pr_flush && !drain_pop && q[head].valid && !q[head].promised &&
                !q[head].outstanding && any_promised && !(pr_addrHit && (cam_idx == head));
  assign pop  = drain_pop | skip;

  assign err_set = alloc_err | fill_err | fill_drop | drain_err | op_bad;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < ENTRIES; i++) q[i] <= '0;
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (pr_flush) begin
      for (int unsigned i = 0; i < ENTRIES; i++) q[i] <= '0;
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (alloc) begin
        q[tail] <= '{valid: 1'b1, addr: PF_ADDR_BITS'(pr_m_ar_addr), outstanding: 1'b1,
                     promised: op_master, wr_beat: '0, rd_beat: '0, last_beat: '0};
        tail <= tail + 1'b1;
      end
      if (pr_addrHit) q[cam_idx].promised <= 1'b1;
      if (fill_en) begin
        if (!fill_drop) q[fill_idx].wr_beat <= q[fill_idx].wr_beat + 1'b1;
        if (m_r_last) begin
          q[fill_idx].outstanding <= 1'b0;
          q[fill_idx].last_beat   <= fill_drop ? BEAT_W'(MAX_BEATS - 1) : q[fill_idx].wr_beat;
        end
      end
      if (drain) q[head].rd_beat <= q[head].rd_beat + 1'b1;
      if (pop) begin
        q[head].valid <= 1'b0;
        head          <= head + 1'b1;
      end
      if (alloc && !pop)      cnt <= cnt + 1'b1;
      else if (!alloc && pop) cnt <= cnt - 1'b1;
    end
  end

  // Beat storage carries no reset; readers are gated by entry state.
  always_ff @(posedge clk) begin
    if (fill_en && !fill_drop && !reset) begin
      beat_mem[fill_idx][BIDX_W'(q[fill_idx].wr_beat)] <= m_r_data;
    end
  end

  // Sticky error survives flush; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        pr_err <= 1'b0;
    else if (err_set) pr_err <= 1'b1;
  end

`ifdef PREFETCH_QUEUE_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_hits   <= '0;
      stat_misses <= '0;
      stat_skips  <= '0;
    end else begin
      if (op_master && cam_hit && (stat_hits != '1))    stat_hits   <= stat_hits + 1'b1;
      if (op_master && !cam_hit && (stat_misses != '1)) stat_misses <= stat_misses + 1'b1;
      if (skip && (stat_skips != '1))                   stat_skips  <= stat_skips + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_prefetch_data_queue.sv
// Directed self-checking bench for prefetch_data_queue with hand-computed expectations.
module tb_prefetch_data_queue;

  logic        clk;
  logic        reset;
  logic        pr_flush;
  logic [2:0]  pr_opCode;
  logic [63:0] pr_m_ar_addr;
  logic [63:0] m_r_data;
  logic        m_r_last;
  logic        pr_addrHit;
  logic        pr_hasOutstanding;
  logic [6:0]  pr_reqCnt;
  logic        pr_almostFull;
  logic        pr_r_valid;
  logic        pr_r_in_last;
  logic [63:0] pr_r_data;
  logic        pr_err;
`ifdef PREFETCH_QUEUE_STATS_EN
  logic [31:0] stat_hits, stat_misses, stat_skips;
`endif

  int checks   = 0;
  int failures = 0;

  prefetch_data_queue dut (
    .clk               (clk),
    .reset             (reset),
    .pr_flush          (pr_flush),
    .pr_opCode         (pr_opCode),
    .pr_m_ar_addr      (pr_m_ar_addr),
    .m_r_data          (m_r_data),
    .m_r_last          (m_r_last),
    .pr_addrHit        (pr_addrHit),
    .pr_hasOutstanding (pr_hasOutstanding),
    .pr_reqCnt         (pr_reqCnt),
    .pr_almostFull     (pr_almostFull),
    .pr_r_valid        (pr_r_valid),
    .pr_r_in_last      (pr_r_in_last),
    .pr_r_data         (pr_r_data),
`ifdef PREFETCH_QUEUE_STATS_EN
    .stat_hits         (stat_hits),
    .stat_misses       (stat_misses),
    .stat_skips        (stat_skips),
`endif
    .pr_err            (pr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; the rising edge consumes them.
  task automatic drive(input logic [2:0] op, input logic [63:0] addr, input logic [63:0] data,
                       input logic last, input logic flush);
    @(negedge clk);
    pr_opCode    = op;
    pr_m_ar_addr = addr;
    m_r_data     = data;
    m_r_last     = last;
    pr_flush     = flush;
  endtask

  task automatic idle();
    drive(3'd0, 64'h0, 64'h0, 1'b0, 1'b0);
  endtask

  task automatic reset_pulse(input string tag);
    @(negedge clk);
    pr_opCode = 3'd0;
    pr_flush  = 1'b0;
    m_r_last  = 1'b0;
    #2 reset = 1'b1;
    #1;
    check({tag, "_cnt"}, 64'(pr_reqCnt), 64'd0);
    check({tag, "_out"}, 64'(pr_hasOutstanding), 64'd0);
    check({tag, "_err"}, 64'(pr_err), 64'd0);
    check({tag, "_rvalid"}, 64'(pr_r_valid), 64'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    pr_flush     = 1'b0;
    pr_opCode    = 3'd0;
    pr_m_ar_addr = '0;
    m_r_data     = '0;
    m_r_last     = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_cnt",    64'(pr_reqCnt), 64'd0);
    check("rst_out",    64'(pr_hasOutstanding), 64'd0);
    check("rst_af",     64'(pr_almostFull), 64'd0);
    check("rst_rvalid", 64'(pr_r_valid), 64'd0);
    check("rst_inlast", 64'(pr_r_in_last), 64'd0);
    check("rst_data",   pr_r_data, 64'd0);
    check("rst_err",    64'(pr_err), 64'd0);

    // Two prefetches, four beats each, then a master hit on the first.
    drive(3'd1, 64'h1000, 0, 0, 0);
    drive(3'd1, 64'h1040, 0, 0, 0);
    for (int b = 0; b < 4; b++) drive(3'd3, 0, 64'hA0 + 64'(b), b == 3, 0);
    for (int b = 0; b < 4; b++) drive(3'd3, 0, 64'hB0 + 64'(b), b == 3, 0);
    idle(); #1;
    check("t1_cnt",    64'(pr_reqCnt), 64'd2);
    check("t1_out",    64'(pr_hasOutstanding), 64'd0);
    check("t1_rvalid", 64'(pr_r_valid), 64'd0);
    drive(3'd2, 64'h1000, 0, 0, 0); #1;
    check("t1_hit", 64'(pr_addrHit), 64'd1);
    idle(); #1;
    check("t1_rvalid2", 64'(pr_r_valid), 64'd1);
    for (int b = 0; b < 4; b++) begin
      drive(3'd4, 0, 0, 0, 0); #1;
      check($sformatf("t1_data%0d", b), pr_r_data, 64'hA0 + 64'(b));
      check($sformatf("t1_last%0d", b), 64'(pr_r_in_last), 64'(b == 3));
    end
    idle(); #1;
    check("t1_cnt_after", 64'(pr_reqCnt), 64'd1);
    check("t1_rvalid3",   64'(pr_r_valid), 64'd0);

    // Master miss allocates a promised entry; stale 0x1040 head is skipped.
    drive(3'd2, 64'h9000, 0, 0, 0); #1;
    check("t2_hit", 64'(pr_addrHit), 64'd0);
    idle(); #1;
    check("t2_cnt", 64'(pr_reqCnt), 64'd2);
    check("t2_out", 64'(pr_hasOutstanding), 64'd1);
    drive(3'd3, 0, 64'hC0, 0, 0); #1;
    check("t2_cnt_skip", 64'(pr_reqCnt), 64'd1);
    drive(3'd3, 0, 64'hC1, 1, 0);
    idle(); #1;
    check("t2_rvalid", 64'(pr_r_valid), 64'd1);
    check("t2_out2",   64'(pr_hasOutstanding), 64'd0);
    for (int b = 0; b < 2; b++) begin
      drive(3'd4, 0, 0, 0, 0); #1;
      check($sformatf("t2_data%0d", b), pr_r_data, 64'hC0 + 64'(b));
      check($sformatf("t2_last%0d", b), 64'(pr_r_in_last), 64'(b == 1));
    end
    idle(); #1;
    check("t2_cnt_end", 64'(pr_reqCnt), 64'd0);

    // Hit on the younger entry makes the older head get skipped.
    drive(3'd1, 64'h1000, 0, 0, 0);
    drive(3'd1, 64'h1040, 0, 0, 0);
    drive(3'd3, 0, 64'hE0, 1, 0);
    drive(3'd3, 0, 64'hF0, 1, 0);
    drive(3'd2, 64'h1040, 0, 0, 0); #1;
    check("t3_hit", 64'(pr_addrHit), 64'd1);
    idle(); #1;
    check("t3_cnt",    64'(pr_reqCnt), 64'd2);
    check("t3_rvalid", 64'(pr_r_valid), 64'd0);
    idle(); #1;
    check("t3_cnt_skip", 64'(pr_reqCnt), 64'd1);
    check("t3_rvalid2",  64'(pr_r_valid), 64'd1);
    check("t3_data",     pr_r_data, 64'hF0);
    check("t3_inlast",   64'(pr_r_in_last), 64'd1);
    drive(3'd4, 0, 0, 0, 0);
    idle(); #1;
    check("t3_cnt_end", 64'(pr_reqCnt), 64'd0);

    // Fill the queue through the wrap point.
    for (int i = 0; i < 61; i++) drive(3'd1, 64'h10000 + 64'(i * 64), 0, 0, 0);
    idle(); #1;
    check("t4_cnt61", 64'(pr_reqCnt), 64'd61);
    check("t4_af61",  64'(pr_almostFull), 64'd0);
    drive(3'd1, 64'h10000 + 64'(61 * 64), 0, 0, 0);
    idle(); #1;
    check("t4_cnt62", 64'(pr_reqCnt), 64'd62);
    check("t4_af62",  64'(pr_almostFull), 64'd1);
    drive(3'd1, 64'h10000 + 64'(62 * 64), 0, 0, 0);
    drive(3'd1, 64'h10000 + 64'(63 * 64), 0, 0, 0);
    idle(); #1;
    check("t4_cnt64", 64'(pr_reqCnt), 64'd64);
    check("t4_err0",  64'(pr_err), 64'd0);
    drive(3'd1, 64'h7777000, 0, 0, 0);
    idle(); #1;
    check("t4_cnt_full", 64'(pr_reqCnt), 64'd64);
    check("t4_err1",     64'(pr_err), 64'd1);
    check("t4_out",      64'(pr_hasOutstanding), 64'd1);

    // Flush beats an otherwise-hitting master request.
    drive(3'd2, 64'h10000, 0, 0, 1); #1;
    check("t5_hit", 64'(pr_addrHit), 64'd0);
    idle(); #1;
    check("t5_cnt", 64'(pr_reqCnt), 64'd0);
    check("t5_out", 64'(pr_hasOutstanding), 64'd0);
    check("t5_err", 64'(pr_err), 64'd1);
    drive(3'd1, 64'h4000, 0, 0, 1);
    idle(); #1;
    check("t5_cnt2", 64'(pr_reqCnt), 64'd0);
    check("t5_out2", 64'(pr_hasOutstanding), 64'd0);

    // Reset in the middle of a burst.
    drive(3'd1, 64'h3000, 0, 0, 0);
    drive(3'd3, 0, 64'h55, 0, 0);
    reset_pulse("r1");

    drive(3'd5, 0, 0, 0, 0);
    idle(); #1;
    check("r2_badop_err", 64'(pr_err), 64'd1);
    reset_pulse("r2");

    drive(3'd4, 0, 0, 0, 0);
    idle(); #1;
    check("r3_drain_empty_err", 64'(pr_err), 64'd1);
    reset_pulse("r3");

    drive(3'd3, 0, 64'h66, 1, 0);
    idle(); #1;
    check("r4_fill_none_err", 64'(pr_err), 64'd1);
    check("r4_cnt", 64'(pr_reqCnt), 64'd0);
    reset_pulse("r4");

    // Fifth beat overflows storage; last still closes the entry.
    drive(3'd2, 64'h2000, 0, 0, 0);
    for (int b = 0; b < 5; b++) begin
      drive(3'd3, 0, 64'hD0 + 64'(b), b == 4, 0);
      if (b == 1) begin
        #1 check("r5_out", 64'(pr_hasOutstanding), 64'd1);
        check("r5_err0", 64'(pr_err), 64'd0);
      end
    end
    idle(); #1;
    check("r5_err",    64'(pr_err), 64'd1);
    check("r5_out2",   64'(pr_hasOutstanding), 64'd0);
    check("r5_rvalid", 64'(pr_r_valid), 64'd1);
    for (int b = 0; b < 4; b++) begin
      drive(3'd4, 0, 0, 0, 0); #1;
      check($sformatf("r5_data%0d", b), pr_r_data, 64'hD0 + 64'(b));
      check($sformatf("r5_last%0d", b), 64'(pr_r_in_last), 64'(b == 3));
    end
    idle(); #1;
    check("r5_cnt_end", 64'(pr_reqCnt), 64'd0);
    check("r5_rvalid2", 64'(pr_r_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
